// File: rtl/md_unit_if.sv
// Issue-side bundle for the multiply/divide unit.
// The issuer drives start/op/A/B and observes busy/done/HI/LO.
interface md_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (output start, op, A, B, input busy, done, HI, LO);
    modport slave  (input start, op, A, B, output busy, done, HI, LO);
endinterface

// File: rtl/md_unit.sv
// Iterative radix-2 multiply/divide with HI/LO result registers.
// Latency: WIDTH+1 cycles for mul/div (WIDTH steps + sign fix), MTHI/MTLO write at the sampling edge.
// Backpressure: busy is high while an operation is in flight; start is ignored until it falls.
module md_unit #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    md_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic               is_div;
    logic               neg_lo;
    logic               neg_hi;
    logic               div0;
    logic [WIDTH-1:0]   opb;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic               busy;
    logic               done;

    logic               op_signed;
    logic               a_sign;
    logic               b_sign;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;

    always_comb begin
        op_signed = bus.op[0];
        a_sign    = op_signed & bus.A[WIDTH-1];
        b_sign    = op_signed & bus.B[WIDTH-1];
        a_mag     = a_sign ? -bus.A : bus.A;
        b_mag     = b_sign ? -bus.B : bus.B;

        // Multiply keeps the multiplier in acc's low half and shifts the partial product in from the top.
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opb : {WIDTH{1'b0}})};
        // Divide keeps the dividend in acc's low half; quotient bits enter at the bottom as it shifts out.
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opb};
        div_diff  = div_shift - {1'b0, opb};
        div_rem   = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        acc_step  = is_div ? {div_rem, acc[WIDTH-2:0], div_ge} : {mul_sum, acc[WIDTH-1:1]};

        prod_fix  = neg_lo ? -acc : acc;
        q_fix     = div0 ? {WIDTH{1'b1}} : (neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
        // With a zero divisor the remainder is |A|; re-applying A's sign restores the raw dividend.
        r_fix     = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            div0   <= 1'b0;
            opb    <= '0;
            acc    <= '0;
            hi     <= '0;
            lo     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (!bus.op[2]) begin
                            is_div <= bus.op[1];
                            neg_lo <= a_sign ^ b_sign;
                            neg_hi <= bus.op[1] & a_sign;
                            div0   <= bus.op[1] & (bus.B == '0);
                            opb    <= bus.op[1] ? b_mag : a_mag;
                            acc    <= {{WIDTH{1'b0}}, (bus.op[1] ? a_mag : b_mag)};
                            cnt    <= '0;
                            busy   <= 1'b1;
                            state  <= RUN;
                        end else if (bus.op == 3'd4) begin
                            hi <= bus.A;
                        end else if (bus.op == 3'd5) begin
                            lo <= bus.A;
                        end
                    end
                end
                RUN: begin
                    acc <= acc_step;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH-1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (is_div) begin
                        hi <= r_fix;
                        lo <= q_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.HI   = hi;
    assign bus.LO   = lo;
endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: expected HI/LO pairs are queued at issue and compared when done pulses.
module tb_md_unit;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    md_unit_if #(.WIDTH(32)) bus();
    md_unit #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks   = 0;
    int failures = 0;
    logic [63:0] sb_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        int ia, ib;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ia = $signed(a);
        ib = $signed(b);
        case (op)
            3'd0: r = {32'h0, a} * {32'h0, b};
            3'd1: r = 64'(sa * sb);
            3'd2: r = (b == 32'h0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
            3'd3: begin
                if (b == 32'h0)
                    r = {a, 32'hFFFFFFFF};
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF)
                    r = {32'h0, 32'h80000000};
                else
                    r = {32'(ia % ib), 32'(ia / ib)};
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one mul/div op, optionally pulses a stray MTLO at cycle inject_at, and checks timing and result.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int inject_at);
        logic [63:0] held;
        logic [63:0] got;
        int cyc;
        int dones;
        logic held_bad;
        held = {bus.HI, bus.LO};
        sb_q.push_back(exp);
        bus.start = 1'b1;
        bus.op    = op;
        bus.A     = a;
        bus.B     = b;
        step();
        bus.start = 1'b0;
        bus.op    = 3'($urandom_range(0, 7));
        bus.A     = $urandom;
        bus.B     = $urandom;
        chk({tag, "_busy_rise"}, 64'(bus.busy), 64'd1);
        chk({tag, "_done_low"}, 64'(bus.done), 64'd0);
        cyc = 1;
        dones = 0;
        held_bad = 1'b0;
        while (bus.busy && cyc < 100) begin
            if (cyc == inject_at) begin
                bus.start = 1'b1;
                bus.op    = 3'd5;
                bus.A     = 32'hDEADBEEF;
            end else begin
                bus.start = 1'b0;
            end
            step();
            if (bus.busy) begin
                cyc++;
                if ({bus.HI, bus.LO} !== held) held_bad = 1'b1;
                if (bus.done) dones++;
            end
        end
        bus.start = 1'b0;
        chk({tag, "_busy_cycles"}, 64'(cyc), 64'd33);
        chk({tag, "_hilo_held"}, 64'(held_bad), 64'd0);
        chk({tag, "_early_done"}, 64'(dones), 64'd0);
        chk({tag, "_done_pulse"}, 64'(bus.done), 64'd1);
        if (sb_q.size() > 0) begin
            got = sb_q.pop_front();
            chk({tag, "_hilo"}, {bus.HI, bus.LO}, got);
        end else begin
            chk({tag, "_sb_empty"}, 64'(sb_q.size()), 64'd1);
        end
    endtask

    initial begin
        logic [63:0] snap;
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        int dcnt;

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.A     = '0;
        bus.B     = '0;
        #12;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_hilo", {bus.HI, bus.LO}, 64'd0);
        rst_n = 1'b1;
        step();

        bus.start = 1'b1; bus.op = 3'd4; bus.A = 32'h12345678;
        step();
        bus.start = 1'b0;
        chk("mthi_hi", 64'(bus.HI), 64'h12345678);
        chk("mthi_busy", 64'(bus.busy), 64'd0);
        chk("mthi_done", 64'(bus.done), 64'd0);

        bus.start = 1'b1; bus.op = 3'd5; bus.A = 32'hCAFEF00D;
        step();
        bus.start = 1'b0;
        chk("mtlo_lo", 64'(bus.LO), 64'hCAFEF00D);

        snap = {bus.HI, bus.LO};
        bus.start = 1'b1; bus.op = 3'd6; bus.A = 32'h0;
        step();
        bus.op = 3'd7;
        step();
        bus.start = 1'b0;
        chk("nop_hilo", {bus.HI, bus.LO}, snap);
        chk("nop_busy", 64'(bus.busy), 64'd0);

        run_op("multu_max", 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, -1);
        run_op("mult_neg",  3'd1, 32'hFFFFFFFD, 32'd7,        64'hFFFFFFFF_FFFFFFEB, -1);
        run_op("divu",      3'd2, 32'd100,      32'd5,        64'h00000000_00000014, -1);
        run_op("div_neg",   3'd3, 32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD, -1);
        run_op("div_by0",   3'd3, 32'd100,      32'd0,        64'h00000064_FFFFFFFF, -1);
        run_op("divu_by0",  3'd2, 32'd7,        32'd0,        64'h00000007_FFFFFFFF, -1);
        run_op("div_neg0",  3'd3, 32'hFFFFFFF9, 32'd0,        64'hFFFFFFF9_FFFFFFFF, -1);
        run_op("div_ovf",   3'd3, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, -1);
        run_op("mult_min",  3'd1, 32'h80000000, 32'h80000000, 64'h40000000_00000000, -1);
        run_op("div_rem",   3'd3, 32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD, -1);

        for (int i = 0; i < 6; i++) begin
            rop = 3'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = (i == 5) ? 32'($urandom_range(1, 9)) : $urandom;
            run_op("rand", rop, ra, rb, model(rop, ra, rb), -1);
        end

        bus.start = 1'b1; bus.op = 3'd4; bus.A = 32'h12345678;
        step();
        bus.start = 1'b0;
        chk("seq_mthi", 64'(bus.HI), 64'h12345678);
        chk("seq_mthi_busy", 64'(bus.busy), 64'd0);
        run_op("seq_multu_inj", 3'd0, 32'd3, 32'd4, 64'h00000000_0000000C, 10);

        bus.start = 1'b1; bus.op = 3'd4; bus.A = 32'hAAAAAAAA;
        step();
        bus.op = 3'd5; bus.A = 32'h55555555;
        step();
        bus.op = 3'd2; bus.A = 32'd100; bus.B = 32'd3;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        chk("abort_hilo", {bus.HI, bus.LO}, 64'd0);
        step();
        step();
        rst_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.done || bus.busy) dcnt++;
        end
        chk("abort_no_done", 64'(dcnt), 64'd0);
        run_op("post_reset", 3'd0, 32'd5, 32'd6, 64'h00000000_0000001E, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/md_unit.md
# md_unit

Multi-cycle multiply/divide responder for the datapath. It accepts one operation per start pulse from the issuing stage, iterates over 32 cycles, and holds the 64-bit result in HI/LO. While an operation is in flight it asserts `busy` so the issuer stalls. It complements the single-cycle combinational ALU.

## Interface
Parameters:
- `WIDTH`, 32, operand width; the iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request strobe; sampled only when `busy`=0.
- `op`  in  3  operation code:
  - 0 MULTU, 1 MULT, 2 DIVU, 3 DIV, 4 MTHI, 5 MTLO.
  - 6 and 7 are no-ops.
- `A`  in  WIDTH  first operand: multiplicand, dividend, or MTHI/MTLO data.
- `B`  in  WIDTH  second operand: multiplier or divisor.
- `busy`  out  1  operation in flight; new starts are ignored.
- `done`  out  1  one-cycle pulse when HI/LO receive a mul/div result.
- `HI`  out  WIDTH  high product word or remainder.
- `LO`  out  WIDTH  low product word or quotient.

## Operation
- Reset values: `busy`=0, `done`=0, `HI`=0, `LO`=0, state=IDLE, internal registers cleared.

States:
- **IDLE**
  - `start`=1 with op 0–3:
    - latch |A| and |B| (raw values for unsigned ops);
    - latch the result sign flags and zero the accumulator;
    - counter := 0, go to RUN.
  - `start`=1 with op 4: `HI` := A at that edge; remain in IDLE; `busy` stays 0.
  - `start`=1 with op 5: `LO` := A at that edge; remain in IDLE; `busy` stays 0.
  - `start`=1 with op 6 or 7: no state change.
- **RUN**
  - One radix-2 step per cycle:
    - multiply: shift-add;
    - divide: restoring shift-subtract.
  - Counter increments each cycle; after the step with counter = WIDTH-1, go to FIX.
- **FIX**
  - Apply sign correction.
  - Write `HI`/`LO`, pulse `done`, return to IDLE.

Arithmetic rules:
- Products are full 64-bit; no truncation.
- MULT: negate the 64-bit magnitude product when the operand signs differ.
- DIV quotient: negative when the operand signs differ, truncated toward zero.
- DIV remainder: takes the sign of the dividend.
- DIV 0x80000000 / 0xFFFFFFFF: `LO`=0x80000000, `HI`=0 (natural wrap).
- Divide by zero, both DIV and DIVU: `LO`=0xFFFFFFFF, `HI`=A (original dividend). Latency is unchanged.

Boundary behaviour:
- `start` while `busy`=1: ignored entirely, including MTHI/MTLO. The issuer must hold and retry.
- Operand and `op` changes after the accepting edge have no effect; all values are latched.
- `rst_n` low mid-operation: aborts immediately and asynchronously; outputs return to reset values; no `done`.
- `HI`/`LO` keep their old values throughout RUN and change only at the FIX edge.

## Timing
- Edge E0 samples `start` with op 0–3.
- `busy`=1 from just after E0 until just after E(WIDTH+1), i.e. 33 cycles for WIDTH=32.
  - E1..E32 are RUN steps.
  - E33 is FIX: `HI`/`LO` update, `busy` falls, `done`=1 for exactly the cycle after E33.
- Back-to-back operation: `start` sampled at E34 is accepted. There is no dead cycle beyond `busy`.
- MTHI/MTLO: zero-latency register write at the sampling edge; `done` is not pulsed.
- `busy` and `done` are registered outputs; neither depends combinationally on `start`.

## Test plan
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> `busy` high exactly 33 cycles; then `HI`=0xFFFFFFFE, `LO`=0x00000001; `done` pulses once.
- MULT A=0xFFFFFFFD (-3), B=7 -> `HI`=0xFFFFFFFF, `LO`=0xFFFFFFEB (-21).
- DIVU A=100, B=5 -> `LO`=20, `HI`=0.
- DIV A=0xFFFFFFF9 (-7), B=2 -> `LO`=0xFFFFFFFD, `HI`=0xFFFFFFFF.
- DIV A=100, B=0 -> after 33 cycles `LO`=0xFFFFFFFF, `HI`=100.
- Combined sequence:
  - MTHI A=0x12345678 while idle -> `HI`=0x12345678 on the next cycle, `busy` stays 0.
  - Then start MULTU 3×4; pulse `start` with op=5 at cycle 10 -> ignored, `LO`=12 after completion.
  - Start a new op and drop `rst_n` at cycle 5 -> `busy`=0, `HI`=`LO`=0 immediately, no `done`.
